// File: rtl/malu_iter.sv
`timescale 1ns/1ps
// malu_iter: multi-cycle RV32M/RV64M arithmetic unit.
// Multiplies complete after a fixed latency; divides use an iterative radix-2
// restoring divider that produces one quotient bit per cycle.
// One operation is in flight at a time.
//
// Handshake: a request is accepted on a rising edge where i_valid && o_ready.
// A result is consumed on a rising edge where o_valid && i_ready. o_valid and
// o_result hold until consumed. o_ready is low from accept until the result
// has been consumed, so a new request can never be accepted in the same cycle
// a result leaves. i_flush returns the unit to IDLE and overrides everything.
module malu_iter #(
    parameter int XLEN    = 32,
    parameter int MUL_LAT = 2
) (
    input  logic            i_clk,
    input  logic            i_rst_n,
    input  logic            i_valid,
    output logic            o_ready,
    input  logic [2:0]      i_op,
    input  logic [XLEN-1:0] i_x,
    input  logic [XLEN-1:0] i_y,
    input  logic            i_flush,
    output logic            o_valid,
    input  logic            i_ready,
    output logic [XLEN-1:0] o_result
);

    // Counter must reach both MUL_LAT-1 and XLEN-1.
    localparam int CNT_W = $clog2(XLEN + MUL_LAT + 1);

    localparam logic [XLEN-1:0] MOST_NEG = {1'b1, {(XLEN-1){1'b0}}};

    // DIV_INIT/DIV_ITER/DIV_FIX are the entry, iteration and fix-up phases
    // of the divide state.
    typedef enum logic [2:0] {
        S_IDLE     = 3'd0,
        S_MUL      = 3'd1,
        S_DIV_INIT = 3'd2,
        S_DIV_ITER = 3'd3,
        S_DIV_FIX  = 3'd4,
        S_DONE     = 3'd5
    } state_t;

    state_t          r_state;
    logic [1:0]      r_op;       // op[2] is already encoded in the state
    logic [XLEN-1:0] r_x;
    logic [XLEN-1:0] r_y;
    logic [CNT_W-1:0] r_cnt;
    logic [XLEN-1:0] r_rem;      // partial remainder
    logic [XLEN-1:0] r_quo;      // dividend shifts out, quotient shifts in
    logic [XLEN-1:0] r_den;      // divisor magnitude
    logic            r_neg_q;
    logic            r_neg_r;
    logic            r_valid;
    logic            r_ready;
    logic [XLEN-1:0] r_result;

    // Multiply datapath (operates on latched operands).
    logic              w_x_sgn;
    logic              w_y_sgn;
    logic [2*XLEN-1:0] w_x_ext;
    logic [2*XLEN-1:0] w_y_ext;
    logic [2*XLEN-1:0] w_prod;
    logic [XLEN-1:0]   w_mul_res;

    // Divide datapath.
    logic            w_div_sgn;
    logic            w_x_neg;
    logic            w_y_neg;
    logic [XLEN-1:0] w_x_abs;
    logic [XLEN-1:0] w_y_abs;
    logic            w_y_zero;
    logic            w_ovf;
    logic [XLEN:0]   w_shift;
    logic [XLEN:0]   w_diff;
    logic            w_q_bit;
    logic [XLEN-1:0] w_quo_fix;
    logic [XLEN-1:0] w_rem_fix;

    // Multiply: sign-extend both operands to 2*XLEN so the low 2*XLEN bits of
    // an unsigned product equal the signed/mixed/unsigned product.
    always_comb begin
        w_x_sgn   = (r_op != 2'b11);          // MUL, MULH, MULHSU
        w_y_sgn   = ~r_op[1];                 // MUL, MULH
        w_x_ext   = {{XLEN{w_x_sgn & r_x[XLEN-1]}}, r_x};
        w_y_ext   = {{XLEN{w_y_sgn & r_y[XLEN-1]}}, r_y};
        w_prod    = w_x_ext * w_y_ext;
        w_mul_res = (r_op == 2'b00) ? w_prod[XLEN-1:0] : w_prod[2*XLEN-1:XLEN];
    end

    // Divide: operand magnitudes, special-case detection, one restoring step
    // and the final sign fix-up.
    always_comb begin
        w_div_sgn = ~r_op[0];                 // DIV, REM
        w_x_neg   = w_div_sgn & r_x[XLEN-1];
        w_y_neg   = w_div_sgn & r_y[XLEN-1];
        w_x_abs   = w_x_neg ? -r_x : r_x;
        w_y_abs   = w_y_neg ? -r_y : r_y;
        w_y_zero  = (r_y == '0);
        w_ovf     = w_div_sgn && (r_x == MOST_NEG) && (r_y == '1);
        w_shift   = {r_rem, r_quo[XLEN-1]};
        w_diff    = w_shift - {1'b0, r_den};
        w_q_bit   = ~w_diff[XLEN];            // no borrow: subtract succeeds
        w_quo_fix = r_neg_q ? -r_quo : r_quo;
        w_rem_fix = r_neg_r ? -r_rem : r_rem;
    end

    // Control FSM with registered handshake outputs and result.
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_state  <= S_IDLE;
            r_op     <= '0;
            r_x      <= '0;
            r_y      <= '0;
            r_cnt    <= '0;
            r_rem    <= '0;
            r_quo    <= '0;
            r_den    <= '0;
            r_neg_q  <= 1'b0;
            r_neg_r  <= 1'b0;
            r_valid  <= 1'b0;
            r_ready  <= 1'b1;
            r_result <= '0;
        end else if (i_flush) begin
            // Abort: any request presented this cycle is dropped as well.
            r_state <= S_IDLE;
            r_valid <= 1'b0;
            r_ready <= 1'b1;
            r_cnt   <= '0;
        end else begin
            case (r_state)
                S_IDLE: begin
                    if (i_valid) begin
                        r_op    <= i_op[1:0];
                        r_x     <= i_x;
                        r_y     <= i_y;
                        r_cnt   <= '0;
                        r_ready <= 1'b0;
                        r_state <= i_op[2] ? S_DIV_INIT : S_MUL;
                    end
                end
                S_MUL: begin
                    if (r_cnt == CNT_W'(MUL_LAT - 1)) begin
                        r_result <= w_mul_res;
                        r_valid  <= 1'b1;
                        r_state  <= S_DONE;
                    end else begin
                        r_cnt <= r_cnt + CNT_W'(1);
                    end
                end
                S_DIV_INIT: begin
                    if (w_y_zero) begin
                        // Divide by zero: quotient all-ones, remainder = x.
                        r_result <= r_op[1] ? r_x : '1;
                        r_valid  <= 1'b1;
                        r_state  <= S_DONE;
                    end else if (w_ovf) begin
                        // Most-negative / -1: quotient = x, remainder = 0.
                        r_result <= r_op[1] ? '0 : r_x;
                        r_valid  <= 1'b1;
                        r_state  <= S_DONE;
                    end else begin
                        r_quo   <= w_x_abs;
                        r_den   <= w_y_abs;
                        r_rem   <= '0;
                        r_neg_q <= w_x_neg ^ w_y_neg;
                        r_neg_r <= w_x_neg;
                        r_cnt   <= '0;
                        r_state <= S_DIV_ITER;
                    end
                end
                S_DIV_ITER: begin
                    r_rem <= w_q_bit ? w_diff[XLEN-1:0] : w_shift[XLEN-1:0];
                    r_quo <= {r_quo[XLEN-2:0], w_q_bit};
                    if (r_cnt == CNT_W'(XLEN - 1)) begin
                        r_state <= S_DIV_FIX;
                    end else begin
                        r_cnt <= r_cnt + CNT_W'(1);
                    end
                end
                S_DIV_FIX: begin
                    r_result <= r_op[1] ? w_rem_fix : w_quo_fix;
                    r_valid  <= 1'b1;
                    r_state  <= S_DONE;
                end
                S_DONE: begin
                    if (i_ready) begin
                        r_valid <= 1'b0;
                        r_ready <= 1'b1;
                        r_state <= S_IDLE;
                    end
                end
                default: begin
                    r_valid <= 1'b0;
                    r_ready <= 1'b1;
                    r_state <= S_IDLE;
                end
            endcase
        end
    end

    assign o_ready  = r_ready;
    assign o_valid  = r_valid;
    assign o_result = r_result;

endmodule

// File: tb/tb_malu_iter.sv
`timescale 1ns/1ps
// Directed bench for malu_iter: a 32-bit instance (MUL_LAT=2) and a 64-bit
// instance (MUL_LAT=1) sharing clock and reset.
module tb_malu_iter;

    localparam logic [2:0] OP_MUL    = 3'b000;
    localparam logic [2:0] OP_MULH   = 3'b001;
    localparam logic [2:0] OP_MULHSU = 3'b010;
    localparam logic [2:0] OP_MULHU  = 3'b011;
    localparam logic [2:0] OP_DIV    = 3'b100;
    localparam logic [2:0] OP_DIVU   = 3'b101;
    localparam logic [2:0] OP_REM    = 3'b110;
    localparam logic [2:0] OP_REMU   = 3'b111;

    // Clock and reset
    logic clk = 1'b0;
    logic rst_n;
    always #5 clk = ~clk;

    // 32-bit instance signals
    logic        i_valid;
    logic        o_ready;
    logic [2:0]  i_op;
    logic [31:0] i_x;
    logic [31:0] i_y;
    logic        i_flush;
    logic        o_valid;
    logic        i_ready;
    logic [31:0] o_result;

    // 64-bit instance signals
    logic        i_valid_64;
    logic        o_ready_64;
    logic [2:0]  i_op_64;
    logic [63:0] i_x_64;
    logic [63:0] i_y_64;
    logic        i_flush_64;
    logic        o_valid_64;
    logic        i_ready_64;
    logic [63:0] o_result_64;

    int n_checks = 0;
    int n_errors = 0;

    malu_iter #(.XLEN(32), .MUL_LAT(2)) dut32 (
        .i_clk    (clk),
        .i_rst_n  (rst_n),
        .i_valid  (i_valid),
        .o_ready  (o_ready),
        .i_op     (i_op),
        .i_x      (i_x),
        .i_y      (i_y),
        .i_flush  (i_flush),
        .o_valid  (o_valid),
        .i_ready  (i_ready),
        .o_result (o_result)
    );

    malu_iter #(.XLEN(64), .MUL_LAT(1)) dut64 (
        .i_clk    (clk),
        .i_rst_n  (rst_n),
        .i_valid  (i_valid_64),
        .o_ready  (o_ready_64),
        .i_op     (i_op_64),
        .i_x      (i_x_64),
        .i_y      (i_y_64),
        .i_flush  (i_flush_64),
        .o_valid  (o_valid_64),
        .i_ready  (i_ready_64),
        .o_result (o_result_64)
    );

    // Driver: present one request, scramble operands after accept, wait for
    // the result (bounded), then consume it. lat counts edges after accept.
    task automatic run_op(input logic [2:0] op, input logic [31:0] a,
                          input logic [31:0] b, output logic [31:0] res,
                          output int lat, output bit busy_ok);
        i_op    = op;
        i_x     = a;
        i_y     = b;
        i_valid = 1'b1;
        @(posedge clk);
        #1;
        i_valid = 1'b0;
        i_x     = $urandom;
        i_y     = $urandom;
        i_op    = 3'($urandom);
        lat     = 0;
        busy_ok = 1'b1;
        while (!o_valid && lat < 200) begin
            if (o_ready) busy_ok = 1'b0;
            @(posedge clk);
            #1;
            lat++;
        end
        res     = o_result;
        i_ready = 1'b1;
        @(posedge clk);
        #1;
        i_ready = 1'b0;
    endtask

    task automatic run_op64(input logic [2:0] op, input logic [63:0] a,
                            input logic [63:0] b, output logic [63:0] res,
                            output int lat);
        i_op_64    = op;
        i_x_64     = a;
        i_y_64     = b;
        i_valid_64 = 1'b1;
        @(posedge clk);
        #1;
        i_valid_64 = 1'b0;
        i_x_64     = {$urandom, $urandom};
        i_y_64     = {$urandom, $urandom};
        lat        = 0;
        while (!o_valid_64 && lat < 200) begin
            @(posedge clk);
            #1;
            lat++;
        end
        res        = o_result_64;
        i_ready_64 = 1'b1;
        @(posedge clk);
        #1;
        i_ready_64 = 1'b0;
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        n_checks++;
        if (o_valid !== 1'b0) begin
            n_errors++;
            $display("FAIL reset_valid: got %b expected 0", o_valid);
        end
        n_checks++;
        if (o_ready !== 1'b1) begin
            n_errors++;
            $display("FAIL reset_ready: got %b expected 1", o_ready);
        end
        n_checks++;
        if (o_result !== 32'h0) begin
            n_errors++;
            $display("FAIL reset_result: got %h expected 00000000", o_result);
        end
        n_checks++;
        if (o_ready_64 !== 1'b1 || o_valid_64 !== 1'b0) begin
            n_errors++;
            $display("FAIL reset_64: got ready=%b valid=%b expected ready=1 valid=0",
                     o_ready_64, o_valid_64);
        end
        #2;
        rst_n = 1'b1;
        @(posedge clk);
        #1;
    endtask

    task automatic test_mul();
        logic [31:0] res;
        int lat;
        bit busy_ok;
        run_op(OP_MUL, 32'h0000_0007, 32'hFFFF_FFFD, res, lat, busy_ok);
        n_checks++;
        if (res !== 32'hFFFF_FFEB) begin
            n_errors++;
            $display("FAIL mul_result: got %h expected ffffffeb", res);
        end
        n_checks++;
        if (lat !== 2) begin
            n_errors++;
            $display("FAIL mul_latency: got %0d expected 2", lat);
        end
        n_checks++;
        if (busy_ok !== 1'b1) begin
            n_errors++;
            $display("FAIL mul_busy_ready: got ready high while busy, expected low");
        end
        run_op(OP_MULH, 32'h8000_0000, 32'hFFFF_FFFF, res, lat, busy_ok);
        n_checks++;
        if (res !== 32'h0000_0000) begin
            n_errors++;
            $display("FAIL mulh_result: got %h expected 00000000", res);
        end
        run_op(OP_MULHSU, 32'h8000_0000, 32'hFFFF_FFFF, res, lat, busy_ok);
        n_checks++;
        if (res !== 32'h8000_0000) begin
            n_errors++;
            $display("FAIL mulhsu_result: got %h expected 80000000", res);
        end
        run_op(OP_MULHU, 32'h8000_0000, 32'hFFFF_FFFF, res, lat, busy_ok);
        n_checks++;
        if (res !== 32'h7FFF_FFFF) begin
            n_errors++;
            $display("FAIL mulhu_result: got %h expected 7fffffff", res);
        end
        n_checks++;
        if (lat !== 2) begin
            n_errors++;
            $display("FAIL mulhu_latency: got %0d expected 2", lat);
        end
    endtask

    task automatic test_div();
        logic [31:0] res;
        int lat;
        bit busy_ok;
        run_op(OP_DIV, 32'hFFFF_FFF9, 32'h0000_0002, res, lat, busy_ok);
        n_checks++;
        if (res !== 32'hFFFF_FFFD) begin
            n_errors++;
            $display("FAIL div_result: got %h expected fffffffd", res);
        end
        n_checks++;
        if (lat !== 34) begin
            n_errors++;
            $display("FAIL div_latency: got %0d expected 34", lat);
        end
        n_checks++;
        if (busy_ok !== 1'b1) begin
            n_errors++;
            $display("FAIL div_busy_ready: got ready high while busy, expected low");
        end
        run_op(OP_REM, 32'hFFFF_FFF9, 32'h0000_0002, res, lat, busy_ok);
        n_checks++;
        if (res !== 32'hFFFF_FFFF) begin
            n_errors++;
            $display("FAIL rem_result: got %h expected ffffffff", res);
        end
        n_checks++;
        if (lat !== 34) begin
            n_errors++;
            $display("FAIL rem_latency: got %0d expected 34", lat);
        end
        run_op(OP_DIVU, 32'hFFFF_FFFE, 32'h0000_0003, res, lat, busy_ok);
        n_checks++;
        if (res !== 32'h5555_5554) begin
            n_errors++;
            $display("FAIL divu_large_result: got %h expected 55555554", res);
        end
        run_op(OP_REM, 32'h0000_0007, 32'hFFFF_FFFE, res, lat, busy_ok);
        n_checks++;
        if (res !== 32'h0000_0001) begin
            n_errors++;
            $display("FAIL rem_pos_neg_result: got %h expected 00000001", res);
        end
    endtask

    task automatic test_special();
        logic [31:0] res;
        int lat;
        bit busy_ok;
        run_op(OP_DIVU, 32'h0000_0005, 32'h0000_0000, res, lat, busy_ok);
        n_checks++;
        if (res !== 32'hFFFF_FFFF) begin
            n_errors++;
            $display("FAIL divu_zero_result: got %h expected ffffffff", res);
        end
        n_checks++;
        if (lat !== 1) begin
            n_errors++;
            $display("FAIL divu_zero_latency: got %0d expected 1", lat);
        end
        run_op(OP_REM, 32'h0000_0005, 32'h0000_0000, res, lat, busy_ok);
        n_checks++;
        if (res !== 32'h0000_0005) begin
            n_errors++;
            $display("FAIL rem_zero_result: got %h expected 00000005", res);
        end
        run_op(OP_DIV, 32'h8000_0000, 32'hFFFF_FFFF, res, lat, busy_ok);
        n_checks++;
        if (res !== 32'h8000_0000) begin
            n_errors++;
            $display("FAIL div_ovf_result: got %h expected 80000000", res);
        end
        n_checks++;
        if (lat !== 1) begin
            n_errors++;
            $display("FAIL div_ovf_latency: got %0d expected 1", lat);
        end
        run_op(OP_REM, 32'h8000_0000, 32'hFFFF_FFFF, res, lat, busy_ok);
        n_checks++;
        if (res !== 32'h0000_0000) begin
            n_errors++;
            $display("FAIL rem_ovf_result: got %h expected 00000000", res);
        end
    endtask

    task automatic test_backpressure();
        int lat;
        bit stayed_idle;
        i_op    = OP_MUL;
        i_x     = 32'd9;
        i_y     = 32'd5;
        i_valid = 1'b1;
        @(posedge clk);
        #1;
        i_valid = 1'b0;
        lat = 0;
        while (!o_valid && lat < 20) begin
            @(posedge clk);
            #1;
            lat++;
        end
        n_checks++;
        if (o_result !== 32'd45) begin
            n_errors++;
            $display("FAIL bp_result: got %h expected 0000002d", o_result);
        end
        // Second request presented while the result is held.
        i_op    = OP_MUL;
        i_x     = 32'd2;
        i_y     = 32'd2;
        i_valid = 1'b1;
        for (int c = 0; c < 5; c++) begin
            @(posedge clk);
            #1;
            n_checks++;
            if (o_valid !== 1'b1 || o_ready !== 1'b0 || o_result !== 32'd45) begin
                n_errors++;
                $display("FAIL bp_hold cycle %0d: got valid=%b ready=%b result=%h expected 1 0 0000002d",
                         c, o_valid, o_ready, o_result);
            end
        end
        i_valid = 1'b0;
        i_ready = 1'b1;
        @(posedge clk);
        #1;
        i_ready = 1'b0;
        n_checks++;
        if (o_valid !== 1'b0 || o_ready !== 1'b1) begin
            n_errors++;
            $display("FAIL bp_release: got valid=%b ready=%b expected 0 1", o_valid, o_ready);
        end
        stayed_idle = 1'b1;
        repeat (4) begin
            @(posedge clk);
            #1;
            if (o_valid !== 1'b0 || o_ready !== 1'b1) stayed_idle = 1'b0;
        end
        n_checks++;
        if (stayed_idle !== 1'b1) begin
            n_errors++;
            $display("FAIL bp_second_ignored: got activity after release, expected idle");
        end
    endtask

    task automatic test_flush();
        logic [31:0] res;
        int lat;
        bit busy_ok;
        bit no_valid;
        // Flush in the middle of a divide, with a competing request.
        i_op    = OP_DIVU;
        i_x     = 32'd1000;
        i_y     = 32'd3;
        i_valid = 1'b1;
        @(posedge clk);
        #1;
        i_valid = 1'b0;
        repeat (10) @(posedge clk);
        #1;
        i_flush = 1'b1;
        i_valid = 1'b1;
        i_op    = OP_MUL;
        i_x     = 32'd3;
        i_y     = 32'd4;
        @(posedge clk);
        #1;
        i_flush = 1'b0;
        i_valid = 1'b0;
        n_checks++;
        if (o_ready !== 1'b1 || o_valid !== 1'b0) begin
            n_errors++;
            $display("FAIL flush_div: got ready=%b valid=%b expected 1 0", o_ready, o_valid);
        end
        no_valid = 1'b1;
        repeat (40) begin
            @(posedge clk);
            #1;
            if (o_valid !== 1'b0) no_valid = 1'b0;
        end
        n_checks++;
        if (no_valid !== 1'b1) begin
            n_errors++;
            $display("FAIL flush_no_valid: got o_valid high after flush, expected low");
        end
        run_op(OP_MUL, 32'd6, 32'd7, res, lat, busy_ok);
        n_checks++;
        if (res !== 32'd42 || lat !== 2) begin
            n_errors++;
            $display("FAIL flush_next_mul: got %h lat %0d expected 0000002a lat 2", res, lat);
        end
        // Flush while a result is held in DONE.
        i_op    = OP_MULHU;
        i_x     = 32'hFFFF_FFFF;
        i_y     = 32'h0000_0010;
        i_valid = 1'b1;
        @(posedge clk);
        #1;
        i_valid = 1'b0;
        lat = 0;
        while (!o_valid && lat < 20) begin
            @(posedge clk);
            #1;
            lat++;
        end
        n_checks++;
        if (o_valid !== 1'b1 || o_result !== 32'h0000_000F) begin
            n_errors++;
            $display("FAIL flush_pre_done: got valid=%b result=%h expected 1 0000000f",
                     o_valid, o_result);
        end
        i_flush = 1'b1;
        @(posedge clk);
        #1;
        i_flush = 1'b0;
        n_checks++;
        if (o_valid !== 1'b0 || o_ready !== 1'b1) begin
            n_errors++;
            $display("FAIL flush_done: got valid=%b ready=%b expected 0 1", o_valid, o_ready);
        end
        // Flush in IDLE is a no-op.
        i_flush = 1'b1;
        @(posedge clk);
        #1;
        i_flush = 1'b0;
        n_checks++;
        if (o_valid !== 1'b0 || o_ready !== 1'b1) begin
            n_errors++;
            $display("FAIL flush_idle: got valid=%b ready=%b expected 0 1", o_valid, o_ready);
        end
    endtask

    task automatic test_async_reset();
        logic [31:0] res;
        int lat;
        bit busy_ok;
        i_op    = OP_DIVU;
        i_x     = 32'd100;
        i_y     = 32'd7;
        i_valid = 1'b1;
        @(posedge clk);
        #1;
        i_valid = 1'b0;
        repeat (5) @(posedge clk);
        #3;
        rst_n = 1'b0;
        #1;
        n_checks++;
        if (o_valid !== 1'b0 || o_ready !== 1'b1 || o_result !== 32'h0) begin
            n_errors++;
            $display("FAIL async_reset: got valid=%b ready=%b result=%h expected 0 1 00000000",
                     o_valid, o_ready, o_result);
        end
        #3;
        rst_n = 1'b1;
        @(posedge clk);
        #1;
        run_op(OP_DIVU, 32'd100, 32'd7, res, lat, busy_ok);
        n_checks++;
        if (res !== 32'd14 || lat !== 34) begin
            n_errors++;
            $display("FAIL post_reset_divu: got %h lat %0d expected 0000000e lat 34", res, lat);
        end
        run_op(OP_REMU, 32'd100, 32'd7, res, lat, busy_ok);
        n_checks++;
        if (res !== 32'd2) begin
            n_errors++;
            $display("FAIL post_reset_remu: got %h expected 00000002", res);
        end
    endtask

    task automatic test_xlen64();
        logic [63:0] res;
        int lat;
        run_op64(OP_MULHU, 64'hFFFF_FFFF_FFFF_FFFF, 64'hFFFF_FFFF_FFFF_FFFF, res, lat);
        n_checks++;
        if (res !== 64'hFFFF_FFFF_FFFF_FFFE) begin
            n_errors++;
            $display("FAIL mulhu64_result: got %h expected fffffffffffffffe", res);
        end
        n_checks++;
        if (lat !== 1) begin
            n_errors++;
            $display("FAIL mulhu64_latency: got %0d expected 1", lat);
        end
        run_op64(OP_MUL, 64'hFFFF_FFFF_FFFF_FFFF, 64'hFFFF_FFFF_FFFF_FFFF, res, lat);
        n_checks++;
        if (res !== 64'h0000_0000_0000_0001) begin
            n_errors++;
            $display("FAIL mul64_result: got %h expected 0000000000000001", res);
        end
        run_op64(OP_DIV, 64'hFFFF_FFFF_FFFF_FF9C, 64'h0000_0000_0000_0007, res, lat);
        n_checks++;
        if (res !== 64'hFFFF_FFFF_FFFF_FFF2 || lat !== 66) begin
            n_errors++;
            $display("FAIL div64_result: got %h lat %0d expected fffffffffffffff2 lat 66", res, lat);
        end
    endtask

    initial begin
        i_valid    = 1'b0;
        i_op       = '0;
        i_x        = '0;
        i_y        = '0;
        i_flush    = 1'b0;
        i_ready    = 1'b0;
        i_valid_64 = 1'b0;
        i_op_64    = '0;
        i_x_64     = '0;
        i_y_64     = '0;
        i_flush_64 = 1'b0;
        i_ready_64 = 1'b0;
        test_reset();
        test_mul();
        test_div();
        test_special();
        test_backpressure();
        test_flush();
        test_async_reset();
        test_xlen64();
        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule

// File: doc/malu_iter.md
Name: malu_iter

Overview:
- Multi-cycle RV32M/RV64M arithmetic unit with a valid/ready handshake. Executes all eight M-extension ops: MUL, MULH, MULHSU, MULHU, DIV, DIVU, REM, REMU.
- Multiplies use a fixed-latency path. Divides use an iterative radix-2 restoring divider.
- Sits in the execute stage beside the integer ALU. The core stalls on o_ready/o_valid and flushes via i_flush on redirect.
- Holds one operation in flight at a time.

Parameters:
- XLEN, 32, operand/result width (32 or 64).
- MUL_LAT, 2, cycles from accept to o_valid for multiply ops (>=1).

Ports:
- i_clk  input  1  clock, rising edge.
- i_rst_n  input  1  asynchronous active-low reset.
- i_valid  input  1  request valid.
- o_ready  output  1  unit can accept a request.
- i_op  input  3  funct3 encoding: 000 MUL, 001 MULH, 010 MULHSU, 011 MULHU, 100 DIV, 101 DIVU, 110 REM, 111 REMU.
- i_x  input  XLEN  rs1 operand.
- i_y  input  XLEN  rs2 operand.
- i_flush  input  1  abort any in-flight op.
- o_valid  output  1  result valid.
- i_ready  input  1  consumer accepts result.
- o_result  output  XLEN  result.

Behaviour:
- Reset (async, i_rst_n low): state=IDLE, o_valid=0, o_result=0, o_ready=1, all counters and internal registers 0.
- States:
  - IDLE: o_ready=1. Accept when i_valid&&o_ready at a rising edge. Latch op and operands. Go to MUL (op[2]=0) or DIV (op[2]=1).
  - MUL: counter runs MUL_LAT-1 cycles, then DONE. Product width is 2*XLEN. Operand extension: MUL/MULH signed x signed; MULHSU signed x unsigned; MULHU unsigned x unsigned. MUL returns low XLEN bits; the other three return high XLEN bits.
  - DIV:
    - Entry cycle computes |x| and |y| for signed ops (DIV/REM), raw values for DIVU/REMU.
    - Then XLEN shift-subtract iterations, one quotient bit per cycle.
    - Final cycle applies sign fix-up: quotient negative iff signs differ; remainder takes the dividend's sign. Then DONE.
    - Accept at edge k gives o_valid high after edge k+XLEN+2.
  - DONE: o_valid=1, o_result stable. When o_valid&&i_ready, go to IDLE. o_ready stays 0 in DONE, so there is no back-to-back accept in the same cycle.
- Latency: MUL ops, o_valid rises after edge k+MUL_LAT. MUL_LAT=1 means the result is valid the cycle after accept.
- Division special cases skip iteration and go to DONE at edge k+1:
  - y=0: DIV/DIVU give all-ones; REM/REMU give x.
  - Signed overflow (x = most negative, y = -1, DIV/REM only): DIV gives x; REM gives 0.
- Backpressure: in DONE with i_ready=0, o_valid and o_result hold indefinitely.
- i_flush:
  - Synchronous; wins over every other event. Next state is IDLE and o_valid drops the following cycle.
  - An i_valid in the same cycle as i_flush is not accepted.
  - A flush in IDLE is a no-op.
- Asynchronous reset mid-operation discards the op immediately. No output glitch beyond the reset values.
- i_op, i_x and i_y are don't-care outside the accept cycle. Operand changes after accept must not affect the result.

Test Plan:
- XLEN=32, MUL_LAT=2: MUL x=0x0000_0007, y=0xFFFF_FFFD -> o_result=0xFFFF_FFEB. o_valid rises exactly 2 cycles after accept; o_ready=0 meanwhile.
- MULH/MULHSU/MULHU with x=0x8000_0000, y=0xFFFF_FFFF -> 0x0000_0000, 0x8000_0000, 0x7FFF_FFFF respectively.
- DIV x=-7 (0xFFFF_FFF9), y=2 -> 0xFFFF_FFFD. REM same operands -> 0xFFFF_FFFF. o_valid after exactly XLEN+2=34 cycles.
- Special cases:
  - DIVU x=5, y=0 -> 0xFFFF_FFFF in 1 cycle.
  - REM x=5, y=0 -> 5.
  - DIV x=0x8000_0000, y=0xFFFF_FFFF -> 0x8000_0000.
  - REM with the same operands -> 0.
- Backpressure and flush:
  - Hold i_ready=0 for 5 cycles in DONE -> o_result stable, o_ready=0, second i_valid ignored.
  - Assert i_flush at iteration 10 of a DIV -> IDLE next cycle, no o_valid, next MUL completes correctly.
- Reset: drop i_rst_n mid-DIV, not aligned to a clock edge -> o_valid=0, o_ready=1, o_result=0 immediately. After release, DIVU 100/7 -> 14, REMU 100/7 -> 2. Repeat with XLEN=64, MUL_LAT=1: MULHU of all-ones x all-ones -> 0xFFFF_FFFF_FFFF_FFFE.
